// File: rtl/clock_divider_bank.sv
// clock_divider_bank: bank of programmable clock-enable dividers with a glitch-free output select.
// Divisor/mode changes and select switches take effect only at period boundaries.
module clock_divider_bank #(
  parameter int CH = 4,
  parameter int W = 8,
  parameter int DEF_DIV = 2,
  parameter int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*W-1:0] div,
  input  logic [CH-1:0]   mode,
  input  logic            load,
  input  logic [CH-1:0]   en,
  input  logic [SW-1:0]   sel,
  output logic [CH-1:0]   clk_out,
  output logic            dclk,
  output logic            sel_busy
);
  localparam logic [SW:0] max_sel = (SW+1)'(CH-1);
  logic [CH-1:0] boundary;
  logic [SW-1:0] pend, cur_sel;
  genvar i;
  for (i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] cnt, a, s, d;
    logic [W:0] half;
    logic m, sm, run, o, nxt;
    assign d = (a == '0) ? W'(1) : a;
    assign half = ({1'b0, d} + (W+1)'(1)) >> 1;
    assign nxt = !run || cnt == d - W'(1);
    // a disabled channel counts as a boundary so the select can move to it at once
    assign boundary[i] = !en[i] || nxt;
    assign clk_out[i] = o;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        o <= 1'b0;
        run <= 1'b0;
        a <= W'(DEF_DIV);
        s <= W'(DEF_DIV);
        m <= 1'b0;
        sm <= 1'b0;
      end else begin
        if (load) begin
          s <= div[i*W +: W];
          sm <= mode[i];
        end
        if (!en[i]) begin
          cnt <= '0;
          o <= 1'b0;
          run <= 1'b0;
        end else if (nxt) begin
          a <= s;
          m <= sm;
          cnt <= '0;
          o <= 1'b1;
          run <= 1'b1;
        end else begin
          cnt <= cnt + W'(1);
          o <= m && (({1'b0, cnt} + (W+1)'(1)) < half);
        end
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= '0;
      cur_sel <= '0;
    end else begin
      pend <= ({1'b0, sel} > max_sel) ? max_sel[SW-1:0] : sel;
      if (pend != cur_sel && boundary[pend]) cur_sel <= pend;
    end
  assign dclk = clk_out[cur_sel];
  assign sel_busy = pend != cur_sel;
endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Parametrised bank of CH independent clock-enable dividers with runtime-programmable divisor, per-channel pulse or square duty mode, per-channel enable, and a select output `dclk`. Divisor and mode updates apply only at period boundaries, and selection switches only at a period boundary, so no truncated periods or glitches occur. It sits between the system clock and the slow-rate consumers (display scan, debounce, tone generation) and replaces fixed /2, /3, /4, /8 dividers.

## Interface
- CH, 4, number of divider channels (2..16)
- W, 8, divisor width; divisor range 1..2^W-1
- DEF_DIV, 2, divisor loaded into every channel at reset
- SW, $clog2(CH), select width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- div  in  CH*W  per-channel divisor; channel i is div[i*W +: W]
- mode  in  CH  per-channel duty mode: 0 = pulse, 1 = square
- load  in  1  capture all `div` and `mode` into shadow registers this cycle
- en  in  CH  per-channel run enable
- sel  in  SW  requested channel for `dclk`
- clk_out  out  CH  registered divided outputs
- dclk  out  1  clk_out[cur_sel]
- sel_busy  out  1  high while the requested select differs from the applied select

## Operation
- Per-channel state: cnt[W], out, run, active divisor A, active mode M, shadow divisor S, shadow mode SM.
- If `load`=1, then S<=div slice and SM<=mode bit for all channels. Shadows are applied only as described below.
- Effective divisor D = max(A,1). A divisor of 0 is treated as 1.
- Channel update, evaluated in priority order each edge:
  - en=0: cnt<=0, out<=0, run<=0.
  - en=1, run=0 (start): A<=S, M<=SM, cnt<=0, out<=1, run<=1.
  - en=1, run=1, cnt==D-1 (wrap): cnt<=0, A<=S, M<=SM, out<=1.
  - otherwise: cnt<=cnt+1; out<=(M==1) && (cnt+1 < ceil(D/2)).
- Resulting waveform per period of D cycles:
  - Pulse mode: high for 1 cycle.
  - Square mode: high for ceil(D/2) cycles, low for floor(D/2) cycles.
  - D=1: constant high in both modes.
- A `load` landing on a wrap edge: the shadow value written this edge is not applied. The wrap applies the previous S. The new value applies at the next wrap.
- Select logic:
  - cur_sel holds the applied select; pend<=sel every cycle.
  - If pend != cur_sel, cur_sel<=pend on the first edge where target channel pend is either starting/wrapping (its out becomes 1 at period start) or has en=0.
  - sel values >= CH: treated as CH-1.
- dclk = clk_out[cur_sel], a mux of registered signals whose select changes on the same edge as the target's period start.
- sel_busy = (pend != cur_sel).
- Reset (asynchronous, rst_n=0), all outputs low:
  - cnt=0, out=0, run=0.
  - A=S=DEF_DIV, M=SM=0.
  - cur_sel=pend=0.
  - clk_out=0, dclk=0, sel_busy=0.

## Timing
- First enabled edge after reset release or after en rises: out=1 on that edge; period length D counts from there.
- `load` to effect: at the next wrap after the load edge. Worst case D_old+1 cycles.
- Select latency:
  - 1 cycle to pend.
  - Then up to D_target cycles until the boundary.
  - 1 cycle if the target is disabled.
- Deasserting en forces out=0 on the next edge, even mid-period.
- rst_n assertion mid-period clears all state immediately, without waiting for a clock edge.

## Test plan
- Reset, en=4'b1111, mode=0, load div={8,4,3,2} on the first cycle:
  - First period uses DEF_DIV=2 on every channel.
  - After the first wrap, channel periods are 2, 3, 4, 8 with 1-cycle pulses.
- Square mode, D=5 and D=6:
  - D=5: out high 3 cycles, low 2, repeating.
  - D=6: out high 3 cycles, low 3.
  - D=1: constant 1.
  - div=0: behaves as D=1.
- Mid-period reload on channel 0, D 8->3 with load at cnt=2:
  - Current period completes at 8 cycles.
  - Subsequent periods are 3 cycles.
  - No period shorter than 3.
- sel 0->3 with channel 3 at D=8 mid-period:
  - sel_busy high until channel 3 wraps.
  - dclk first follows channel 3 on its rising period start.
  - No dclk high shorter than one full pulse.
- en[1] dropped at cnt=2 of D=6 square:
  - clk_out[1]=0 next edge.
  - Re-raising en[1] gives out=1 on the first edge and a full 6-cycle period.
- rst_n asserted asynchronously mid-run:
  - All outputs 0 before the next clock edge.
  - After release, divisors back to DEF_DIV.
